// File: rtl/npu_pkg.sv
// Shared types for the activation-engine command path: descriptor layout,
// completion status codes and dispatcher state encoding.
package npu_pkg;

   localparam int ACT_TAG_W = 4;

   typedef enum logic [1:0] {
      CPL_OK      = 2'b00,
      CPL_SKIPPED = 2'b01,
      CPL_TIMEOUT = 2'b10
   } cpl_status_t;

   typedef struct packed {
      logic [15:0]          length;
      logic [15:0]          src_base;
      logic [15:0]          dst_base;
      logic                 silu;
      logic [ACT_TAG_W-1:0] tag;
   } act_desc_t;

   typedef logic [1:0] disp_state_t;

   localparam logic [1:0] D_IDLE  = 2'd0;
   localparam logic [1:0] D_ISSUE = 2'd1;
   localparam logic [1:0] D_WAIT  = 2'd2;
   localparam logic [1:0] D_CPL   = 2'd3;

   // A zero-length command would make the engine run the full 65536 elements.
   function automatic logic is_zero_len(input act_desc_t d);
      return d.length == 16'd0;
   endfunction

endpackage

// File: rtl/act_desc_fifo.sv
// Descriptor queue: registered storage, combinational head, occupancy count.
module act_desc_fifo
   import npu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  act_desc_t                wdata,
   output act_desc_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   act_desc_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/act_cmd_dispatcher.sv
// Queues activation descriptors and runs them one at a time on the engine,
// skipping zero-length commands and timing out hung operations.
module act_cmd_dispatcher
   import npu_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TAG_W          = ACT_TAG_W,
   parameter int TIMEOUT_CYCLES = 262144
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          desc_valid,
   output logic                          desc_ready,
   input  logic [15:0]                   desc_length,
   input  logic [15:0]                   desc_src_base,
   input  logic [15:0]                   desc_dst_base,
   input  logic                          desc_silu,
   input  logic [TAG_W-1:0]              desc_tag,
   output logic                          eng_cmd_valid,
   input  logic                          eng_cmd_ready,
   output logic [15:0]                   eng_length,
   output logic [15:0]                   eng_src_base,
   output logic [15:0]                   eng_dst_base,
   output logic                          eng_silu_mode,
   input  logic                          eng_done,
   output logic                          cpl_valid,
   output logic [TAG_W-1:0]              cpl_tag,
   output logic [1:0]                    cpl_status,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   disp_state_t        state;
   act_desc_t          wr_desc;
   act_desc_t          head;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               head_zero;
   logic               issue;
   logic [TW-1:0]      wait_cnt;
   logic [TAG_W-1:0]   tag_q;
   cpl_status_t        status_q;

   assign wr_desc = '{length:   desc_length,
                      src_base: desc_src_base,
                      dst_base: desc_dst_base,
                      silu:     desc_silu,
                      tag:      ACT_TAG_W'(desc_tag)};

   assign head_zero = is_zero_len(head);
   assign issue     = (state == D_ISSUE);
   assign push      = desc_valid && !full;
   // The head leaves the queue either on the engine handshake or when skipped.
   assign pop       = !empty && (((state == D_IDLE) && head_zero) ||
                                 (issue && eng_cmd_ready));

   act_desc_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wr_desc),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (queue_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= D_IDLE;
         tag_q    <= '0;
         status_q <= CPL_OK;
         wait_cnt <= '0;
      end else begin
         case (state)
            D_IDLE: begin
               if (!empty) begin
                  if (head_zero) begin
                     tag_q    <= TAG_W'(head.tag);
                     status_q <= CPL_SKIPPED;
                     state    <= D_CPL;
                  end else begin
                     state <= D_ISSUE;
                  end
               end
            end
            D_ISSUE: begin
               if (eng_cmd_ready) begin
                  tag_q    <= TAG_W'(head.tag);
                  wait_cnt <= '0;
                  state    <= D_WAIT;
               end
            end
            D_WAIT: begin
               // A done arriving on the final count still reports OK.
               if (eng_done) begin
                  status_q <= CPL_OK;
                  state    <= D_CPL;
               end else if (wait_cnt == TO_LAST) begin
                  status_q <= CPL_TIMEOUT;
                  state    <= D_CPL;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            D_CPL: begin
               state <= D_IDLE;
            end
            default: begin
               state <= D_IDLE;
            end
         endcase
      end
   end

   assign desc_ready    = !full;
   assign eng_cmd_valid = issue;
   assign eng_length    = issue ? head.length   : 16'd0;
   assign eng_src_base  = issue ? head.src_base : 16'd0;
   assign eng_dst_base  = issue ? head.dst_base : 16'd0;
   assign eng_silu_mode = issue && head.silu;
   assign cpl_valid     = (state == D_CPL);
   assign cpl_tag       = tag_q;
   assign cpl_status    = status_q;
   assign busy          = (state != D_IDLE) || !empty;

endmodule

// File: tb/tb_act_cmd_dispatcher.sv
// Bench for act_cmd_dispatcher: stub engine plus an in-order completion model
// covering issue payload, skip, timeout, stray done and reset behaviour.
module tb_act_cmd_dispatcher;

   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;
   localparam int TO         = 16;
   localparam int NEVER      = 99;
   localparam int RANDOM_K   = -2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [15:0]   desc_length = '0;
   logic [15:0]   desc_src_base = '0;
   logic [15:0]   desc_dst_base = '0;
   logic          desc_silu = 1'b0;
   logic [3:0]    desc_tag = '0;
   logic          eng_cmd_valid;
   logic          eng_cmd_ready = 1'b0;
   logic [15:0]   eng_length;
   logic [15:0]   eng_src_base;
   logic [15:0]   eng_dst_base;
   logic          eng_silu_mode;
   logic          eng_done = 1'b0;
   logic          cpl_valid;
   logic [3:0]    cpl_tag;
   logic [1:0]    cpl_status;
   logic          busy;
   logic [2:0]    queue_count;

   always #5 clk = ~clk;

   act_cmd_dispatcher #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TAG_W          (TAG_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .desc_valid    (desc_valid),
      .desc_ready    (desc_ready),
      .desc_length   (desc_length),
      .desc_src_base (desc_src_base),
      .desc_dst_base (desc_dst_base),
      .desc_silu     (desc_silu),
      .desc_tag      (desc_tag),
      .eng_cmd_valid (eng_cmd_valid),
      .eng_cmd_ready (eng_cmd_ready),
      .eng_length    (eng_length),
      .eng_src_base  (eng_src_base),
      .eng_dst_base  (eng_dst_base),
      .eng_silu_mode (eng_silu_mode),
      .eng_done      (eng_done),
      .cpl_valid     (cpl_valid),
      .cpl_tag       (cpl_tag),
      .cpl_status    (cpl_status),
      .busy          (busy),
      .queue_count   (queue_count)
   );

   typedef struct {
      logic [15:0] len;
      logic [15:0] src;
      logic [15:0] dst;
      logic        silu;
      logic [3:0]  tag;
   } desc_t;

   typedef struct {
      logic [3:0] tag;
      logic [1:0] status;
      int         cyc;
   } cpl_t;

   desc_t  desc_q[$];   // accepted, not yet issued or skipped
   cpl_t   exp_q[$];    // issued, completion expected

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_count = 0;
   int cpl_seen = 0;
   int last_cpl_cyc = 0;

   // Stub engine controls
   logic hold = 1'b0;
   logic rand_ready = 1'b0;
   logic stray_en = 1'b0;
   int   force_k = RANDOM_K;
   logic tracking = 1'b0;
   int   wcnt = 0;
   int   done_k = 0;
   logic outstanding = 1'b0;
   logic prev_pending = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick_k();
      int r;
      if (force_k != RANDOM_K) return force_k;
      r = $urandom_range(0, 9);
      if (r <= 6) return $urandom_range(0, TO - 1);
      if (r == 7) return TO - 1;
      if (r == 8) return TO;
      return NEVER;
   endfunction

   // Stub engine and monitor: drives ready/done for the upcoming edge and
   // compares everything the DUT shows in the current cycle.
   always @(negedge clk) begin
      desc_t d;
      cpl_t  e;
      int    k;
      cyc++;
      if (!rst_n) begin
         eng_cmd_ready = 1'b0;
         eng_done      = 1'b0;
         tracking      = 1'b0;
         outstanding   = 1'b0;
         prev_pending  = 1'b0;
         desc_q.delete();
         exp_q.delete();
      end else begin
         if (cpl_valid) begin
            cpl_seen++;
            last_cpl_cyc = cyc;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("cpl_tag", cpl_tag, e.tag);
               check("cpl_status", cpl_status, e.status);
               check("cpl_cycle", cyc, e.cyc);
               outstanding = 1'b0;
            end else if (desc_q.size() > 0) begin
               d = desc_q.pop_front();
               check("skip_len", d.len, 0);
               check("skip_tag", cpl_tag, d.tag);
               check("skip_status", cpl_status, 2'b01);
            end else begin
               check("cpl_unexpected", 1, 0);
            end
         end
         if (outstanding) check("single_outstanding", eng_cmd_valid, 0);
         if (prev_pending) check("valid_held", eng_cmd_valid, 1);

         if (tracking) begin
            eng_done = (wcnt == done_k);
            wcnt++;
            if (wcnt > TO) tracking = 1'b0;
         end else begin
            eng_done = stray_en && ($urandom_range(0, 7) == 0);
         end
         eng_cmd_ready = hold ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);

         if (eng_cmd_valid) begin
            if (desc_q.size() == 0) begin
               check("issue_unexpected", 1, 0);
            end else begin
               d = desc_q[0];
               check("issue_len", eng_length, d.len);
               check("issue_src", eng_src_base, d.src);
               check("issue_dst", eng_dst_base, d.dst);
               check("issue_silu", eng_silu_mode, d.silu);
               if (eng_cmd_ready) begin
                  void'(desc_q.pop_front());
                  hs_count++;
                  k = pick_k();
                  e.tag    = d.tag;
                  e.status = (k <= TO - 1) ? 2'b00 : 2'b10;
                  e.cyc    = (k <= TO - 1) ? cyc + k + 2 : cyc + TO + 1;
                  exp_q.push_back(e);
                  outstanding = 1'b1;
                  tracking    = 1'b1;
                  wcnt        = 0;
                  done_k      = k;
               end
            end
         end
         prev_pending = eng_cmd_valid && !eng_cmd_ready;
      end
   end

   task automatic push_desc(input logic [15:0] len, input logic [15:0] src,
                            input logic [15:0] dst, input logic silu,
                            input logic [3:0] tag, output int acc);
      desc_t d;
      int    n;
      desc_valid    = 1'b1;
      desc_length   = len;
      desc_src_base = src;
      desc_dst_base = dst;
      desc_silu     = silu;
      desc_tag      = tag;
      n = 0;
      while (!desc_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      acc = cyc;
      if (n >= 200) begin
         check("push_timeout", 0, 1);
         desc_valid = 1'b0;
         return;
      end
      d.len = len; d.src = src; d.dst = dst; d.silu = silu; d.tag = tag;
      desc_q.push_back(d);
      @(negedge clk);
      desc_valid = 1'b0;
   endtask

   task automatic push_rand(input logic [3:0] tag, input logic allow_zero);
      int acc;
      logic [15:0] len;
      len = (allow_zero && $urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      push_desc(len, 16'($urandom), 16'($urandom), 1'($urandom), tag, acc);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((desc_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check({tag, "_drain_timeout"}, 0, 1);
      @(negedge clk);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_count_idle"}, queue_count, 0);
   endtask

   task automatic wait_hs(input int h0);
      int n;
      n = 0;
      while (hs_count == h0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("hs_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_desc_ready"}, desc_ready, 1);
      check({tag, "_cmd_valid"}, eng_cmd_valid, 0);
      check({tag, "_cpl_valid"}, cpl_valid, 0);
      check({tag, "_cpl_tag"}, cpl_tag, 0);
      check({tag, "_cpl_status"}, cpl_status, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_count"}, queue_count, 0);
      check({tag, "_payload"}, {eng_length, eng_src_base}, 0);
      check({tag, "_payload2"}, {eng_dst_base, 15'd0, eng_silu_mode}, 0);
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int acc;
      int h0;
      int c0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single GELU descriptor, immediate accept, done 5 edges after issue
      rand_ready = 1'b0; hold = 1'b0; force_k = 4; stray_en = 1'b0;
      h0 = hs_count;
      push_desc(16'd8, 16'h0100, 16'h0200, 1'b0, 4'd3, acc);
      wait_drain("t1");
      check("t1_handshakes", hs_count - h0, 1);

      // 2: five back-to-back pushes against a stalled engine
      hold = 1'b1; force_k = RANDOM_K;
      for (int i = 0; i < 4; i++) push_rand(4'(8 + i), 1'b0);
      fork
         push_rand(4'd12, 1'b0);
         begin
            repeat (4) @(negedge clk);
            check("t2_ready_low", desc_ready, 0);
            check("t2_count_full", queue_count, 4);
            check("t2_cmd_valid", eng_cmd_valid, 1);
            check("t2_busy", busy, 1);
            hold = 1'b0;
         end
      join
      wait_drain("t2");

      // 3: zero-length descriptor is completed as skipped, never issued
      h0 = hs_count;
      push_desc(16'd0, 16'h1234, 16'h5678, 1'b1, 4'd7, acc);
      wait_drain("t3");
      check("t3_no_issue", hs_count - h0, 0);
      check("t3_skip_latency", ((last_cpl_cyc - acc) <= 3), 1);

      // 4: hung engine times out; next command waits for ready
      force_k = NEVER;
      h0 = hs_count;
      push_desc(16'd5, 16'h0010, 16'h0020, 1'b1, 4'd1, acc);
      wait_hs(h0);
      hold = 1'b1;
      stray_en = 1'b1;
      push_desc(16'd6, 16'h0030, 16'h0040, 1'b0, 4'd2, acc);
      repeat (30) @(negedge clk);
      check("t4_timeout_seen", exp_q.size(), 0);
      check("t4_next_waiting", eng_cmd_valid, 1);
      check("t4_no_second_issue", hs_count - h0, 1);
      force_k = 3;
      hold = 1'b0;
      wait_drain("t4");

      // 5: done coincident with the last timeout count, strays around issue
      rand_ready = 1'b1; force_k = TO - 1;
      for (int i = 0; i < 3; i++) push_rand(4'(i + 4), 1'b0);
      wait_drain("t5");

      // random traffic
      force_k = RANDOM_K;
      for (int i = 0; i < 40; i++) begin
         push_rand(4'($urandom), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("rnd");

      // 6: reset while waiting with two descriptors queued
      rand_ready = 1'b0; stray_en = 1'b0; force_k = NEVER;
      h0 = hs_count;
      push_desc(16'd9, 16'h0a00, 16'h0b00, 1'b0, 4'd10, acc);
      wait_hs(h0);
      push_desc(16'd4, 16'h0c00, 16'h0d00, 1'b1, 4'd11, acc);
      push_desc(16'd0, 16'h0e00, 16'h0f00, 1'b0, 4'd12, acc);
      check("t6_count_pre", queue_count, 2);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t6");
      c0 = cpl_seen;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("t6_no_cpl", cpl_seen - c0, 0);
      check("t6_busy", busy, 0);
      check("t6_count", queue_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
